// File: rtl/flag_evt_pkg.sv
// Shared types for the flag event packer: record layout, widths, saturating increment.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package flag_evt_pkg;

    localparam int BIN_W = 12;
    localparam int FID_W = 6;
    localparam logic [BIN_W-1:0] BIN_MAX = '1;

    typedef enum logic [1:0] {
        REC_SEG     = 2'b01,
        REC_SUM     = 2'b10,
        REC_SUM_OVF = 2'b11
    } rec_type_e;

    typedef struct packed {
        rec_type_e          rtype;
        logic [FID_W-1:0]   frame_id;
        logic [BIN_W-1:0]   a;
        logic [BIN_W-1:0]   b;
    } evt_rec_t;

    function automatic logic [BIN_W-1:0] sat_inc(input logic [BIN_W-1:0] v);
        return (v == BIN_MAX) ? v : v + BIN_W'(1);
    endfunction

endpackage

// File: rtl/flag_event_packer_evt_fifo.sv
// Synchronous FIFO with a two-entry write port and one read port.
// Latency: a write is readable the cycle after it lands.
// Backpressure: writer must respect free; read of an empty FIFO is ignored.
module evt_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_en,
    input  logic [W-1:0]               wr0_dat,
    input  logic                       wr1_en,
    input  logic [W-1:0]               wr1_dat,
    input  logic                       rd_en,
    output logic                       rd_vld,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [AW-1:0] wr1_addr;
    logic [1:0]    n_wr;
    logic          rd_fire;

    always_comb begin
        wr1_addr = wr_ptr + AW'(wr0_en);
        n_wr     = {1'b0, wr0_en} + {1'b0, wr1_en};
        rd_fire  = rd_en && (cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (wr0_en)
            mem[wr_ptr] <= wr0_dat;
        if (wr1_en)
            mem[wr1_addr] <= wr1_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_wr);
            rd_ptr <= rd_ptr + AW'(rd_fire);
            cnt    <= cnt + CW'(n_wr) - CW'(rd_fire);
        end
    end

    // Empty output is forced to zero so the record bus reads 0 out of reset.
    assign rd_vld = (cnt != '0);
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
    assign free   = CW'(DEPTH) - cnt;

endmodule

// File: rtl/flag_event_packer.sv
// Packs runs of flagged bins into segment records and closes each frame with a summary.
// Latency: records visible on m_tvalid one cycle after the accepting beat.
// Backpressure: s_tready registered, high only while the FIFO can absorb two records.
module flag_event_packer
    import flag_evt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_LEN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {IDLE, IN_RUN} run_st_e;

    run_st_e          st;
    logic [BIN_W-1:0] bin_idx;
    logic [BIN_W-1:0] run_start;
    logic [BIN_W-1:0] run_len;
    logic [BIN_W-1:0] seg_cnt;
    logic [BIN_W-1:0] exceed_cnt;
    logic             oversize;
    logic [FID_W-1:0] frame_id;

    logic             acc;
    logic             flag;
    logic             unused_bits;
    logic [BIN_W-1:0] open_start;
    logic [BIN_W-1:0] open_len;
    logic [BIN_W-1:0] close_start;
    logic [BIN_W-1:0] close_len;
    logic             run_close;
    logic             seg_wr;
    logic             sum_wr;
    logic [BIN_W-1:0] seg_cnt_nxt;
    logic [BIN_W-1:0] exc_nxt;
    logic             ovf_nxt;
    evt_rec_t         seg_rec;
    evt_rec_t         sum_rec;

    logic             wr0_en;
    logic [32:0]      wr0_dat;
    logic             wr1_en;
    logic [32:0]      wr1_dat;
    logic             rd_fire;
    logic [32:0]      rd_dat;
    logic [CW-1:0]    fifo_free;
    logic [CW:0]      free_nxt;
    logic [1:0]       n_wr;

    assign acc         = s_tvalid && s_tready;
    assign flag        = s_tdata[0];
    assign unused_bits = ^s_tdata[7:1];
    assign rd_fire     = m_tvalid && m_tready;

    always_comb begin
        open_start  = (st == IN_RUN) ? run_start : bin_idx;
        open_len    = (st == IN_RUN) ? sat_inc(run_len) : BIN_W'(1);
        // A flagged tlast beat belongs to the run it closes; a clear beat does not.
        run_close   = acc && (((st == IN_RUN) && !flag) || (flag && s_tlast));
        close_start = flag ? open_start : run_start;
        close_len   = flag ? open_len   : run_len;
        seg_wr      = run_close && (close_len >= BIN_W'(MIN_LEN));
        sum_wr      = acc && s_tlast;
        seg_cnt_nxt = seg_wr ? sat_inc(seg_cnt) : seg_cnt;
        exc_nxt     = (acc && flag) ? sat_inc(exceed_cnt) : exceed_cnt;
        // The frame is oversize once a beat lands on the saturated index.
        ovf_nxt     = oversize || (acc && (bin_idx == BIN_MAX));

        seg_rec = '{rtype: REC_SEG, frame_id: frame_id, a: close_start, b: close_len};
        sum_rec = '{rtype: (ovf_nxt ? REC_SUM_OVF : REC_SUM), frame_id: frame_id,
                    a: seg_cnt_nxt, b: exc_nxt};

        wr0_en  = seg_wr || sum_wr;
        wr0_dat = seg_wr ? {1'b0, seg_rec} : {1'b1, sum_rec};
        wr1_en  = seg_wr && sum_wr;
        wr1_dat = {1'b1, sum_rec};

        n_wr     = {1'b0, wr0_en} + {1'b0, wr1_en};
        free_nxt = {1'b0, fifo_free} + (CW+1)'(rd_fire) - (CW+1)'(n_wr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            bin_idx    <= '0;
            run_start  <= '0;
            run_len    <= '0;
            seg_cnt    <= '0;
            exceed_cnt <= '0;
            oversize   <= 1'b0;
            frame_id   <= '0;
            s_tready   <= 1'b0;
        end else begin
            s_tready <= (free_nxt >= (CW+1)'(2));
            if (acc) begin
                if (s_tlast) begin
                    st         <= IDLE;
                    bin_idx    <= '0;
                    seg_cnt    <= '0;
                    exceed_cnt <= '0;
                    oversize   <= 1'b0;
                    frame_id   <= frame_id + FID_W'(1);
                end else begin
                    bin_idx    <= sat_inc(bin_idx);
                    seg_cnt    <= seg_cnt_nxt;
                    exceed_cnt <= exc_nxt;
                    oversize   <= ovf_nxt;
                    if (flag) begin
                        st        <= IN_RUN;
                        run_start <= open_start;
                        run_len   <= open_len;
                    end else begin
                        st        <= IDLE;
                    end
                end
            end
        end
    end

    evt_fifo #(
        .W     (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr0_en  (wr0_en),
        .wr0_dat (wr0_dat),
        .wr1_en  (wr1_en),
        .wr1_dat (wr1_dat),
        .rd_en   (m_tready),
        .rd_vld  (m_tvalid),
        .rd_dat  (rd_dat),
        .free    (fifo_free)
    );

    assign m_tdata = rd_dat[31:0];
    assign m_tlast = rd_dat[32];

endmodule

// File: tb/tb_flag_event_packer.sv
// Scoreboard bench for flag_event_packer: MIN_LEN=1 instance (a_*) and MIN_LEN=2 instance (b_*).
module tb_flag_event_packer;

    logic        clk;
    logic        rst;

    logic        a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast;
    logic [7:0]  a_s_tdata;
    logic [31:0] a_m_tdata;
    logic        b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast;
    logic [7:0]  b_s_tdata;
    logic [31:0] b_m_tdata;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    int          n_chk = 0;
    int          n_fail = 0;

    logic        a_prev_stall = 1'b0;
    logic [32:0] a_prev_dat = '0;
    logic        b_prev_stall = 1'b0;
    logic [32:0] b_prev_dat = '0;

    flag_event_packer #(.FIFO_DEPTH(4), .MIN_LEN(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tdata(a_s_tdata), .s_tlast(a_s_tlast),
        .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tdata(a_m_tdata), .m_tlast(a_m_tlast)
    );

    flag_event_packer #(.FIFO_DEPTH(4), .MIN_LEN(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tdata(b_s_tdata), .s_tlast(b_s_tlast),
        .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata), .m_tlast(b_m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitors: pop and compare on each handshake, check hold while stalled.
    always @(negedge clk) begin
        if (rst) begin
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall) begin
                chk("a_hold_vld", a_m_tvalid, 1'b1);
                chk("a_hold_dat", {a_m_tlast, a_m_tdata}, a_prev_dat);
            end
            if (a_m_tvalid && a_m_tready) begin
                if (exp_a.size() == 0)
                    chk("a_extra_rec", exp_a.size(), 1);
                else
                    chk("a_rec", {a_m_tlast, a_m_tdata}, exp_a.pop_front());
            end
            a_prev_stall = a_m_tvalid && !a_m_tready;
            a_prev_dat   = {a_m_tlast, a_m_tdata};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_prev_stall = 1'b0;
        end else begin
            if (b_prev_stall)
                chk("b_hold_dat", {b_m_tlast, b_m_tdata}, b_prev_dat);
            if (b_m_tvalid && b_m_tready) begin
                if (exp_b.size() == 0)
                    chk("b_extra_rec", exp_b.size(), 1);
                else
                    chk("b_rec", {b_m_tlast, b_m_tdata}, exp_b.pop_front());
            end
            b_prev_stall = b_m_tvalid && !b_m_tready;
            b_prev_dat   = {b_m_tlast, b_m_tdata};
        end
    end

    task automatic send(input int which, input bit flag, input bit last);
        int   n;
        logic rdy;
        n = 0;
        @(negedge clk);
        rdy = (which == 0) ? a_s_tready : b_s_tready;
        while (rdy !== 1'b1 && n < 300) begin
            a_s_tvalid = 1'b0;
            b_s_tvalid = 1'b0;
            n++;
            @(negedge clk);
            rdy = (which == 0) ? a_s_tready : b_s_tready;
        end
        chk("send_rdy", rdy, 1'b1);
        if (rdy !== 1'b1) return;
        if (which == 0) begin
            b_s_tvalid = 1'b0;
            a_s_tvalid = 1'b1;
            a_s_tdata  = {7'($urandom), flag};
            a_s_tlast  = last;
        end else begin
            a_s_tvalid = 1'b0;
            b_s_tvalid = 1'b1;
            b_s_tdata  = {7'($urandom), flag};
            b_s_tlast  = last;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        a_s_tvalid = 1'b0;
        b_s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() + exp_b.size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("drain_left", exp_a.size() + exp_b.size(), 0);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        a_s_tvalid = 1'b0;
        b_s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f;
        rst = 1'b1;
        a_s_tvalid = 1'b0; a_s_tdata = '0; a_s_tlast = 1'b0; a_m_tready = 1'b1;
        b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tlast = 1'b0; b_m_tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", a_s_tready, 1'b0);
        chk("rst_m_tvalid", a_m_tvalid, 1'b0);
        chk("rst_m_tdata",  a_m_tdata, 32'h0);
        chk("rst_m_tlast",  a_m_tlast, 1'b0);
        chk("rst_b_m_tvalid", b_m_tvalid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rdy_after_rst", a_s_tready, 1'b1);

        // Frame 0: two runs, summary.
        exp_a.push_back({1'b0, 32'h40001002});
        exp_a.push_back({1'b0, 32'h40005001});
        exp_a.push_back({1'b1, 32'h80002003});
        f = 8'b0010_0110;
        for (int i = 0; i < 8; i++) send(0, f[i], i == 7);
        idle();
        drain();

        // Frame 1: run closed by a flagged tlast beat.
        exp_a.push_back({1'b0, 32'h41002002});
        exp_a.push_back({1'b1, 32'h81001002});
        f = 8'b0000_1100;
        for (int i = 0; i < 4; i++) send(0, f[i], i == 3);
        idle();
        drain();

        // Frame 2: backpressure with four single-bin runs.
        @(posedge clk);
        #1 a_m_tready = 1'b0;
        exp_a.push_back({1'b0, 32'h42000001});
        exp_a.push_back({1'b0, 32'h42002001});
        exp_a.push_back({1'b0, 32'h42004001});
        exp_a.push_back({1'b0, 32'h42006001});
        exp_a.push_back({1'b1, 32'h82004004});
        f = 8'b0101_0101;
        for (int i = 0; i < 6; i++) send(0, f[i], 1'b0);
        idle();
        chk("bp_rdy_low", a_s_tready, 1'b0);
        chk("bp_vld_stall", a_m_tvalid, 1'b1);
        chk("bp_first_dat", a_m_tdata, 32'h42000001);
        fork
            begin
                send(0, f[6], 1'b0);
                send(0, f[7], 1'b1);
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1 a_m_tready = 1'b1;
            end
        join
        drain();

        // MIN_LEN=2 instance after a fresh reset: short run dropped, still counted.
        reset_dut();
        exp_b.push_back({1'b0, 32'h40002002});
        exp_b.push_back({1'b1, 32'h80001003});
        f = 8'b0000_1101;
        for (int i = 0; i < 5; i++) send(1, f[i], i == 4);
        idle();
        drain();

        // 65 empty frames: frame_id wraps 63 -> 0.
        for (int k = 0; k < 65; k++) begin
            exp_a.push_back({1'b1, 32'h80000000 | (32'(k % 64) << 24)});
            send(0, 1'b0, 1'b1);
        end
        idle();
        drain();

        // Oversize frame of 4100 flagged bins.
        reset_dut();
        exp_a.push_back({1'b0, 32'h40000FFF});
        exp_a.push_back({1'b1, 32'hC0001FFF});
        for (int i = 0; i < 4100; i++) send(0, 1'b1, i == 4099);
        idle();
        drain();

        // Reset during bin 3 of a run with a record pending in the FIFO.
        @(posedge clk);
        #1 a_m_tready = 1'b0;
        send(0, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b0);
        send(0, 1'b1, 1'b0);
        @(negedge clk);
        a_s_tvalid = 1'b1;
        a_s_tdata  = 8'h01;
        a_s_tlast  = 1'b0;
        chk("rst_pre_vld", a_m_tvalid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_vld",  a_m_tvalid, 1'b0);
        chk("rst_mid_dat",  a_m_tdata, 32'h0);
        chk("rst_mid_last", a_m_tlast, 1'b0);
        a_s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_rdy", a_s_tready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        a_m_tready = 1'b1;
        exp_a.push_back({1'b1, 32'h80000000});
        send(0, 1'b0, 1'b1);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
